// File: rtl/codec_pkg.sv
// Shared codec serial-link definitions: capture FSM states and I2S framing constants.
package codec_pkg;

    typedef enum logic [2:0] {
        ALIGN,
        SHIFT_L,
        WAIT_L,
        SHIFT_R,
        WAIT_R
    } cap_state_t;

    localparam int   I2S_DELAY  = 1;
    localparam int   CAP_DATA_W = 24;
    localparam logic LEFT_LR    = 1'b0;

endpackage

// File: rtl/i2s_capture_if.sv
// Stereo sample stream handshake: the capture block drives the pair and valid, the consumer drives ready.
interface i2s_capture_if
    import codec_pkg::*;
#(
    parameter int DATA_W = CAP_DATA_W
) ();

    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with a one-cycle rising-edge pulse on the synced level.
module sync_edge (
    input  logic Clk,
    input  logic Reset_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign rise  = sync_reg & ~prev_reg;

endmodule

// File: rtl/i2s_capture.sv
// I2S receiver: oversamples codec SCLK/LRCLK/SDOUT and presents one left/right pair per frame on valid/ready.
module i2s_capture
    import codec_pkg::*;
#(
    parameter int DATA_W   = CAP_DATA_W,
    parameter int SLOT_MAX = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              sclk_in,
    input  logic              lrclk_in,
    input  logic              sdin,
    input  logic              enable,
    input  logic              clr_flags,
    i2s_capture_if.master     smp,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(SLOT_MAX);

    // Pin order in the sync bank: 0 = SCLK, 1 = LRCLK, 2 = data.
    logic [2:0] pin_raw;
    logic [2:0] pin_level;
    logic [2:0] pin_rise;
    logic [2:0] unused_sync;

    assign pin_raw = {sdin, lrclk_in, sclk_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sync_edge u_sync (
                .Clk     (Clk),
                .Reset_n (Reset_n),
                .d       (pin_raw[gi]),
                .level   (pin_level[gi]),
                .rise    (pin_rise[gi])
            );
        end
    endgenerate

    assign unused_sync = {pin_rise[2:1], pin_level[0]};

    logic bit_rise;
    logic lr_s;
    logic sd_s;

    assign bit_rise = pin_rise[0];
    assign lr_s     = pin_level[1];
    assign sd_s     = pin_level[2];

    cap_state_t        state_reg, state_next;
    logic              lr_prev_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] hold_l_reg;
    logic [DATA_W-1:0] sample_l_reg;
    logic [DATA_W-1:0] sample_r_reg;
    logic              valid_reg;
    logic              overrun_reg;
    logic              frame_err_reg;

    logic              lr_chg;
    logic              enter_left;
    logic              cnt_last;
    logic [DATA_W-1:0] shift_next;

    assign lr_chg     = bit_rise && (lr_s != lr_prev_reg);
    assign enter_left = lr_chg && (lr_s == LEFT_LR);
    assign cnt_last   = (bit_cnt_reg == CNT_W'(DATA_W - 1));
    assign shift_next = {shift_reg[DATA_W-2:0], sd_s};

    // FSM: state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ALIGN;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state; the bit sampled on an LR-change rise is the I2S delay bit and never shifted.
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ALIGN;
        end else if (bit_rise) begin
            case (state_reg)
                ALIGN: begin
                    if (enter_left) state_next = SHIFT_L;
                end
                SHIFT_L, SHIFT_R: begin
                    if (lr_chg) begin
                        state_next = enter_left ? SHIFT_L : ALIGN;
                    end else if (cnt_last) begin
                        state_next = (state_reg == SHIFT_L) ? WAIT_L : WAIT_R;
                    end
                end
                WAIT_L: begin
                    if (lr_chg) state_next = enter_left ? SHIFT_L : SHIFT_R;
                end
                WAIT_R: begin
                    if (lr_chg) state_next = enter_left ? SHIFT_L : ALIGN;
                end
                default: state_next = ALIGN;
            endcase
        end
    end

    // FSM: per-cycle strobes for the datapath
    logic in_shift;
    logic in_wait;
    logic shift_en;
    logic wait_tick;
    logic left_done;
    logic frame_done;
    logic short_slot;

    always_comb begin
        in_shift   = (state_reg == SHIFT_L) || (state_reg == SHIFT_R);
        in_wait    = (state_reg == WAIT_L) || (state_reg == WAIT_R);
        shift_en   = enable && bit_rise && !lr_chg && in_shift;
        wait_tick  = enable && bit_rise && !lr_chg && in_wait;
        left_done  = shift_en && cnt_last && (state_reg == SHIFT_L);
        frame_done = shift_en && cnt_last && (state_reg == SHIFT_R);
        short_slot = enable && lr_chg && in_shift;
    end

    logic commit_load;
    logic commit_drop;

    assign commit_load = frame_done && (!valid_reg || smp.sample_ready);
    assign commit_drop = frame_done && valid_reg && !smp.sample_ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lr_prev_reg <= 1'b0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            hold_l_reg  <= '0;
        end else begin
            if (bit_rise) begin
                lr_prev_reg <= lr_s;
            end
            if (!enable) begin
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
            end else if (lr_chg) begin
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end else if (wait_tick && (bit_cnt_reg != CNT_W'(SLOT_MAX - 1))) begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
            // A short slot invalidates any left word already held for this frame.
            if (short_slot) begin
                hold_l_reg <= '0;
            end else if (left_done) begin
                hold_l_reg <= shift_next;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sample_l_reg  <= '0;
            sample_r_reg  <= '0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (commit_load) begin
                sample_l_reg <= hold_l_reg;
                sample_r_reg <= shift_next;
                valid_reg    <= 1'b1;
            end else if (smp.sample_ready) begin
                valid_reg    <= 1'b0;
            end
            if (commit_drop) begin
                overrun_reg <= 1'b1;
            end else if (clr_flags) begin
                overrun_reg <= 1'b0;
            end
            if (short_slot) begin
                frame_err_reg <= 1'b1;
            end else if (clr_flags) begin
                frame_err_reg <= 1'b0;
            end
        end
    end

    assign smp.sample_l     = sample_l_reg;
    assign smp.sample_r     = sample_r_reg;
    assign smp.sample_valid = valid_reg;
    assign overrun          = overrun_reg;
    assign frame_err        = frame_err_reg;

endmodule

// File: doc/i2s_capture.md
Name: i2s_capture

Overview:
- Receive side of the codec serial audio link: deserializes the codec ADC data line (I2S, codec is bit/frame-clock master) into parallel stereo samples for the game logic (record/echo effects, mic input).
- Oversamples the codec SCLK/LRCLK/SDOUT pins with the 50 MHz system clock.
- Presents one left/right pair per frame on a valid/ready handshake.
- Mirror of the existing sample-to-serial transmitter on the same SCLK/LRCLK pair.

Parameters:
- DATA_W, 24, captured sample width; MSB-first; excess slot bits ignored.
- SLOT_MAX, 32, maximum bits per LR half-frame; sizes the bit counter.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- sclk_in  in  1  codec bit clock, asynchronous to Clk
- lrclk_in  in  1  codec frame clock, asynchronous to Clk; 0 = left, 1 = right
- sdin  in  1  codec ADC serial data
- enable  in  1  capture enable
- clr_flags  in  1  one-Clk pulse that clears the sticky flags
- sample_l  out  DATA_W  left sample of the last committed frame
- sample_r  out  DATA_W  right sample of the last committed frame
- sample_valid  out  1  frame available
- sample_ready  in  1  consumer accepts the frame
- overrun  out  1  sticky: a completed frame was dropped
- frame_err  out  1  sticky: a slot was shorter than DATA_W bits

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; shift register, hold register and counters 0; state ALIGN.
- Input sync and sampling:
  - sclk_in, lrclk_in and sdin each pass through a 2-FF synchronizer.
  - SCLK rising edge = synced SCLK was 0 last cycle and is 1 now.
  - All sampling of LR and data happens only on detected rise cycles.
  - Clk must be at least 4x SCLK; slower SCLK ratios are unsupported.
- LR change: sampled LR differs from the previous sampled LR.
  - Per I2S, the bit sampled on the LR-change rise is the delay bit and is discarded.
  - bit_cnt <= 0.
- States (advance only on rise cycles, except reset and enable):
  - ALIGN: wait for an LR change 1->0 (start of left slot) -> SHIFT_L.
  - SHIFT_L: on each rise with bit_cnt < DATA_W, shift sdin in MSB-first and increment bit_cnt.
    - bit_cnt reaches DATA_W: copy the shift register to the left hold register; go to WAIT_L.
  - WAIT_L: ignore bits until LR change 0->1 -> SHIFT_R.
  - SHIFT_R: shift as in SHIFT_L.
    - At bit_cnt = DATA_W: commit the frame (below); go to WAIT_R.
  - WAIT_R: ignore bits until LR change 1->0 -> SHIFT_L.
- Short slot: an LR change while bit_cnt < DATA_W in SHIFT_L or SHIFT_R.
  - Set frame_err.
  - Discard the partial frame, including any held left word.
  - Go to ALIGN; if this change is itself 1->0, go directly to SHIFT_L.
- Commit (registered; sample_valid rises 1 Clk after the rise cycle that captured the last right bit; about 4 Clk after the pin edge):
  - If sample_valid = 0: load sample_l/sample_r; sample_valid <= 1.
  - If sample_valid = 1 and sample_ready = 1 in the same cycle: the old pair is consumed; load the new pair; sample_valid stays 1; no overrun.
  - If sample_valid = 1 and sample_ready = 0: drop the new pair; outputs unchanged; set overrun.
- Handshake:
  - Transfer occurs when sample_valid & sample_ready; sample_valid falls the next cycle unless a commit coincides.
  - sample_l/sample_r are stable whenever sample_valid = 1.
- enable = 0:
  - Forces ALIGN; clears the shift register and bit_cnt.
  - Output registers, sample_valid and flags are untouched; the handshake still completes.
- Flags:
  - clr_flags clears overrun and frame_err.
  - If clr_flags coincides with a new set event, the set wins.
- bit_cnt saturates at SLOT_MAX-1 in the WAIT states; no wrap.

Decomposition:
- Shared package codec_pkg:
  - cap_state_t enum: ALIGN, SHIFT_L, WAIT_L, SHIFT_R, WAIT_R.
  - I2S_DELAY = 1.
  - Default DATA_W = 24; LEFT_LR = 1'b0.
- Sub-module sync_edge:
  - 2-FF synchronizer plus previous-value register; outputs the synced level and a rise pulse.
  - Instantiated for sclk_in (level + rise); lrclk_in and sdin use its synced level only.
  - Same async active-low reset.

Test Plan:
- Reset_n pulsed low mid-left-slot -> all outputs 0 immediately; no capture until the next LR 1->0; the first frame after that is correct.
- 32-bit slots, SCLK = Clk/16, L = 0xA5C3F1, R = 0x123456, ready held 1 -> sample_l = 0xA5C3F1, sample_r = 0x123456; one valid pulse per frame; valid about 4 Clk after the last right data bit's SCLK rise.
- Start streaming mid-right-slot -> the partial frame is discarded; the first valid carries the first complete L/R pair.
- sample_ready = 0 for two frames (F1 = 0x111111/0x222222, F2 = 0x333333/0x444444) -> outputs hold F1; overrun = 1; clr_flags -> overrun = 0.
- Inject a 16-bit slot -> frame_err = 1; no valid for that frame; the next 32-bit frame is captured correctly.
- sample_ready asserted in the exact commit cycle -> no overrun; new pair loaded; sample_valid stays 1. enable dropped mid-slot and restored -> the interrupted frame yields no valid; the next full frame is captured.
